apb_reg_slave: RTL and testbench



---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_reg_slave_if.sv | 23 ++
 rtl/apb_wait_counter.sv | 28 ++
 rtl/apb_reg_slave.sv | 124 ++++++++++++
 tb/tb_apb_reg_slave.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, wait-state limit, completer state encoding
// and the captured-request payload.
package apb_pkg;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned SEL_IDLE = 0;
    localparam int unsigned MAX_WAIT = 15;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between one master and a completer slot.
// The slverr wire exists only when APB_REG_SLAVE_ERR_EN is defined.
interface apb_reg_slave_if;
    import apb_pkg::*;

    logic [SEL_W-1:0]  sel;
    logic              enable;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;
`ifdef APB_REG_SLAVE_ERR_EN
    logic              slverr;

    modport master (output sel, enable, write, addr, wdata, input ready, rdata, slverr);
    modport slave  (input sel, enable, write, addr, wdata, output ready, rdata, slverr);
`else
    modport master (output sel, enable, write, addr, wdata, input ready, rdata);
    modport slave  (input sel, enable, write, addr, wdata, output ready, rdata);
`endif

endinterface

// File: rtl/apb_wait_counter.sv
// Wait-state counter: loads a preset, counts down to zero, and keeps a
// registered zero flag alongside the count.
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= load_val;
            zero  <= (load_val == '0);
        end else if (dec && !zero) begin
            count <= count - CNT_W'(1);
            zero  <= (count == CNT_W'(1));
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer backed by a byte-wide register file with fixed wait states.
// Define APB_REG_SLAVE_ERR_EN to flag out-of-range accesses on slverr.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int unsigned SLAVE_ID    = 1,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic           clk,
    input  logic           reset,
    apb_reg_slave_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    apb_slv_state_t    state_q;
    apb_req_t          req_q;
    logic              ready_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] regs [DEPTH];

    logic [CNT_W-1:0]  cnt;
    logic              cnt_zero;

    logic              hit_c;
    logic              in_range_c;
    logic              req_range_c;
    logic              setup_c;
    logic              abort_c;
    logic              done_c;
    logic              step_c;
    logic              commit_c;
    logic [IDX_W-1:0]  idx_c;
    logic [IDX_W-1:0]  req_idx_c;

    assign hit_c       = (bus.sel == SEL_W'(SLAVE_ID));
    assign in_range_c  = (32'(bus.addr) < DEPTH);
    assign req_range_c = (32'(req_q.addr) < DEPTH);
    assign idx_c       = bus.addr[IDX_W-1:0];
    assign req_idx_c   = req_q.addr[IDX_W-1:0];

    assign setup_c  = (state_q == IDLE) && hit_c && !bus.enable;
    assign abort_c  = (state_q == ACCESS) && !hit_c;
    assign done_c   = (state_q == ACCESS) && hit_c && bus.enable && ready_q;
    assign step_c   = (state_q == ACCESS) && hit_c && bus.enable && !cnt_zero;
    assign commit_c = done_c && req_q.write && req_range_c;

    apb_wait_counter u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (setup_c),
        .load_val (WAIT_LD),
        .dec      (step_c),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Transfer FSM; ready is high exactly while in ACCESS with the counter at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (setup_c) begin
                        state_q <= ACCESS;
                        req_q   <= '{write: bus.write, addr: bus.addr, wdata: bus.wdata};
                        ready_q <= (WAIT_CYCLES == 0);
                        if (!bus.write) begin
                            rdata_q <= in_range_c ? regs[idx_c] : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (abort_c || done_c) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end else if (step_c) begin
                        ready_q <= (cnt == CNT_W'(1));
                    end
                end
            endcase
        end
    end

    // Register file; writes land only on an in-range completion edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_c) begin
            regs[req_idx_c] <= req_q.wdata;
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;

`ifdef APB_REG_SLAVE_ERR_EN
    logic slverr_q;

    // Error response tracks ready for accesses that fall outside the file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slverr_q <= 1'b0;
        end else if (setup_c) begin
            slverr_q <= (WAIT_CYCLES == 0) && !in_range_c;
        end else if (abort_c || done_c) begin
            slverr_q <= 1'b0;
        end else if (step_c) begin
            slverr_q <= (cnt == CNT_W'(1)) && !req_range_c;
        end
    end

    assign bus.slverr = slverr_q;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: a zero-wait and a five-wait instance,
// with expected responses queued at stimulus time and popped on ready.
module tb_apb_reg_slave;
    import apb_pkg::*;

    typedef struct {
        logic [7:0] rdata;
        int         waits;
        logic       err;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    exp_t       sb [$];
    logic [7:0] mem [2][16];
    logic [7:0] last_rd [2];

    apb_reg_slave_if b0 ();
    apb_reg_slave_if b1 ();

    apb_reg_slave #(.SLAVE_ID(1), .DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0.slave)
    );

    apb_reg_slave #(.SLAVE_ID(1), .DEPTH(16), .WAIT_CYCLES(5)) u_w5 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic [1:0] s, input logic e, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        if (which == 0) begin
            b0.sel = s; b0.enable = e; b0.write = w; b0.addr = a; b0.wdata = d;
        end else begin
            b1.sel = s; b1.enable = e; b1.write = w; b1.addr = a; b1.wdata = d;
        end
    endtask

    function automatic logic get_ready(input int which);
        return (which == 0) ? b0.ready : b1.ready;
    endfunction

    function automatic logic [7:0] get_rdata(input int which);
        return (which == 0) ? b0.rdata : b1.rdata;
    endfunction

`ifdef APB_REG_SLAVE_ERR_EN
    function automatic logic get_slverr(input int which);
        return (which == 0) ? b0.slverr : b1.slverr;
    endfunction
`endif

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_rd[k] = 8'h00;
            for (int j = 0; j < 16; j++) mem[k][j] = 8'h00;
        end
    endtask

    // Full setup/access transfer through slave 1 with bounded wait for ready
    task automatic xfer(input int which, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input string tag);
        exp_t e;
        exp_t got_e;
        logic in_rng;
        logic got;
        int   waits;
        in_rng  = (a < 8'd16);
        e.rdata = w ? last_rd[which] : (in_rng ? mem[which][a[3:0]] : 8'h00);
        e.waits = (which == 0) ? 0 : 5;
        e.err   = !in_rng;
        sb.push_back(e);

        drive(which, 2'd1, 1'b0, w, a, d);
        @(posedge clk); #1;
        drive(which, 2'd1, 1'b1, w, a, d);
        got   = 1'b0;
        waits = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (get_ready(which)) begin
                got = 1'b1;
                break;
            end
            waits++;
        end
        check({tag, " ready"}, 32'(got), 32'd1);
        got_e = sb.pop_front();
        if (got) begin
            check({tag, " waits"}, 32'(waits), 32'(got_e.waits));
            check({tag, " rdata"}, 32'(get_rdata(which)), 32'(got_e.rdata));
`ifdef APB_REG_SLAVE_ERR_EN
            check({tag, " slverr"}, 32'(get_slverr(which)), 32'(got_e.err));
`endif
        end
        @(posedge clk); #1;
        drive(which, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check({tag, " ready drop"}, 32'(get_ready(which)), 32'd0);
        if (w && in_rng) mem[which][a[3:0]] = d;
        if (!w) last_rd[which] = got_e.rdata;
    endtask

    initial begin
        logic saw;
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        drive(0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready w0", 32'(b0.ready), 32'd0);
        check("reset rdata w0", 32'(b0.rdata), 32'h00);
        check("reset ready w5", 32'(b1.ready), 32'd0);
        check("reset rdata w5", 32'(b1.rdata), 32'h00);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait write then read back, back-to-back
        xfer(0, 1'b1, 8'h01, 8'h05, "w0 wr 01");
        xfer(0, 1'b0, 8'h01, 8'h00, "w0 rd 01");

        // Five wait states
        xfer(1, 1'b1, 8'h05, 8'h04, "w5 wr 05");
        xfer(1, 1'b0, 8'h05, 8'h00, "w5 rd 05");

        // Another slave's select must be ignored
        drive(0, 2'd2, 1'b0, 1'b1, 8'h02, 8'h33);
        @(posedge clk); #1;
        drive(0, 2'd2, 1'b1, 1'b1, 8'h02, 8'h33);
        saw = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            saw = saw | b0.ready;
        end
        check("sel2 ready", 32'(saw), 32'd0);
        drive(0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
        xfer(0, 1'b0, 8'h02, 8'h00, "w0 rd 02");

        // Enable without a preceding setup phase is ignored
        drive(0, 2'd1, 1'b1, 1'b1, 8'h01, 8'hEE);
        saw = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            saw = saw | b0.ready;
        end
        check("no-setup ready", 32'(saw), 32'd0);
        drive(0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
        xfer(0, 1'b0, 8'h01, 8'h00, "w0 rd 01 after violation");

        // Select dropped mid-wait aborts the write
        drive(1, 2'd1, 1'b0, 1'b1, 8'h03, 8'h77);
        @(posedge clk); #1;
        drive(1, 2'd1, 1'b1, 1'b1, 8'h03, 8'h77);
        repeat (2) @(negedge clk);
        check("abort pre ready", 32'(b1.ready), 32'd0);
        drive(1, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            saw = saw | b1.ready;
        end
        check("abort post ready", 32'(saw), 32'd0);
        xfer(1, 1'b0, 8'h03, 8'h00, "w5 rd 03 after abort");

        // Out-of-range write is dropped, read returns zero
        xfer(0, 1'b1, 8'h20, 8'hAA, "w0 wr 20");
        xfer(0, 1'b0, 8'h20, 8'h00, "w0 rd 20");

        // Reset during the access phase of a write
        drive(0, 2'd1, 1'b0, 1'b1, 8'h00, 8'h11);
        @(posedge clk); #1;
        drive(0, 2'd1, 1'b1, 1'b1, 8'h00, 8'h11);
        #1 reset = 1'b1;
        #1;
        check("mid reset ready", 32'(b0.ready), 32'd0);
        check("mid reset rdata", 32'(b0.rdata), 32'h00);
        @(posedge clk);
        @(negedge clk);
        drive(0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        xfer(0, 1'b0, 8'h00, 8'h00, "w0 rd 00 after reset");
        xfer(0, 1'b0, 8'h01, 8'h00, "w0 rd 01 after reset");
        xfer(1, 1'b0, 8'h05, 8'h00, "w5 rd 05 after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
